// File: rtl/tra_elink_framer.sv
// E-link transmit framer: one 76-bit CAN message -> SOP, 10 payload bytes, [CRC-8], EOP.
// Define TRA_ELINK_CRC_EN to insert a CRC-8 (poly 0x07) symbol between the last payload byte and EOP.
module tra_elink_framer (
  input  logic        clk,
  input  logic        rst,
  input  logic [75:0] msg_in,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic        byte_ready,
  output logic [7:0]  byte_out,
  output logic        kchar_out,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] SOP_K  = 8'h3C;
  localparam logic [7:0] EOP_K  = 8'hDC;
  localparam logic [7:0] IDLE_K = 8'hBC;
  localparam logic [3:0] LAST_BYTE = 4'd9;

  // Handshakes: a message transfers on a clock edge where msg_valid && msg_ready;
  // a symbol is consumed on a clock edge where byte_ready is high outside IDLE.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SOP,
    S_PAYLOAD,
`ifdef TRA_ELINK_CRC_EN
    S_CRC,
`endif
    S_EOP
  } state_t;

  state_t      r_state;
  logic [79:0] r_shreg;
  logic [3:0]  r_cnt;
  logic [7:0]  r_byte;
  logic        r_k;
  logic        r_msg_ready;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  w_next_byte;

`ifdef TRA_ELINK_CRC_EN
  logic [7:0] r_crc;

  function automatic logic [7:0] crc8_fold(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  assign w_next_byte = r_shreg[79:72];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_byte      <= IDLE_K;
      r_k         <= 1'b1;
      r_msg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef TRA_ELINK_CRC_EN
      r_crc       <= 8'h00;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (msg_valid && r_msg_ready) begin
            r_shreg     <= {msg_in, 4'h0};
            r_byte      <= SOP_K;
            r_k         <= 1'b1;
            r_msg_ready <= 1'b0;
            r_busy      <= 1'b1;
`ifdef TRA_ELINK_CRC_EN
            r_crc       <= 8'h00;
`endif
            r_state     <= S_SOP;
          end
        end

        S_SOP: begin
          if (byte_ready) begin
            r_byte  <= w_next_byte;
            r_k     <= 1'b0;
            r_shreg <= {r_shreg[71:0], 8'h00};
            r_cnt   <= '0;
`ifdef TRA_ELINK_CRC_EN
            r_crc   <= crc8_fold(r_crc, w_next_byte);
`endif
            r_state <= S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          if (byte_ready) begin
            if (r_cnt != LAST_BYTE) begin
              r_byte  <= w_next_byte;
              r_k     <= 1'b0;
              r_shreg <= {r_shreg[71:0], 8'h00};
              r_cnt   <= r_cnt + 4'd1;
`ifdef TRA_ELINK_CRC_EN
              r_crc   <= crc8_fold(r_crc, w_next_byte);
`endif
            end else begin
`ifdef TRA_ELINK_CRC_EN
              // Last payload byte was folded on the previous consume, so r_crc is final here.
              r_byte  <= r_crc;
              r_k     <= 1'b0;
              r_state <= S_CRC;
`else
              r_byte  <= EOP_K;
              r_k     <= 1'b1;
              r_state <= S_EOP;
`endif
            end
          end
        end

`ifdef TRA_ELINK_CRC_EN
        S_CRC: begin
          if (byte_ready) begin
            r_byte  <= EOP_K;
            r_k     <= 1'b1;
            r_state <= S_EOP;
          end
        end
`endif

        S_EOP: begin
          if (byte_ready) begin
            r_byte      <= IDLE_K;
            r_k         <= 1'b1;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_msg_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_byte      <= IDLE_K;
          r_k         <= 1'b1;
          r_busy      <= 1'b0;
          r_msg_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_out  = r_byte;
  assign kchar_out = r_k;
  assign msg_ready = r_msg_ready;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_tra_elink_framer.sv
// Bench for tra_elink_framer: directed frames with known symbol lists plus randomized
// traffic checked cycle-by-cycle against a frame-level reference model.
module tb_tra_elink_framer;

  localparam logic [7:0] SOP_K  = 8'h3C;
  localparam logic [7:0] EOP_K  = 8'hDC;
  localparam logic [7:0] IDLE_K = 8'hBC;
`ifdef TRA_ELINK_CRC_EN
  localparam int FRAME_LEN = 13;
`else
  localparam int FRAME_LEN = 12;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [75:0] msg_in = '0;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_out;
  logic        kchar_out;
  logic        busy;
  logic        done;

  tra_elink_framer dut (
    .clk(clk), .rst(rst), .msg_in(msg_in), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .byte_ready(byte_ready), .byte_out(byte_out), .kchar_out(kchar_out), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: whole frame computed from the message, CRC by polynomial long division
  function automatic logic [7:0] ref_crc(input logic [79:0] p);
    logic [87:0] r;
    r = {p, 8'h00};
    for (int i = 87; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  logic [8:0] exp_q[$];   // {k, symbol} still to be presented in the current frame
  logic [8:0] cap_q[$];   // symbols seen consumed, for known-answer checks
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       mon_en = 1'b0;
  logic [8:0] exp_cur;

  function automatic void build_frame(input logic [75:0] m);
    logic [79:0] p;
    p = {m, 4'h0};
    exp_q.delete();
    exp_q.push_back({1'b1, SOP_K});
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, p[79 - 8*i -: 8]});
`ifdef TRA_ELINK_CRC_EN
    exp_q.push_back({1'b0, ref_crc(p)});
`endif
    exp_q.push_back({1'b1, EOP_K});
  endfunction

  // scoreboard: check outputs mid-cycle, then predict the effect of the coming edge
  always @(negedge clk) begin
    if (mon_en) begin
      exp_cur = m_busy ? exp_q[0] : {1'b1, IDLE_K};
      check_eq("symbol", {23'd0, kchar_out, byte_out}, {23'd0, exp_cur});
      check_eq("busy", {31'd0, busy}, {31'd0, m_busy});
      check_eq("msg_ready", {31'd0, msg_ready}, {31'd0, !m_busy});
      check_eq("done", {31'd0, done}, {31'd0, m_done});
      m_done = 1'b0;
      if (!rst) begin
        m_busy = 1'b0;
        exp_q.delete();
      end else if (!m_busy) begin
        if (msg_valid) begin
          build_frame(msg_in);
          m_busy = 1'b1;
        end
      end else if (byte_ready) begin
        cap_q.push_back({kchar_out, byte_out});
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [75:0] rand_msg();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[75:0];
  endfunction

  // mode 0: byte_ready high; 1: random; 2: repeating 1-0-0-1
  task automatic run_frame(input logic [75:0] m, input int mode, input bit noise, input bit chk_len);
    int n_busy;
    int ph;
    cap_q.delete();
    msg_in = m;
    msg_valid = 1'b1;
    byte_ready = 1'b1;
    cyc();
    msg_valid = 1'b0;
    n_busy = busy ? 1 : 0;
    ph = 0;
    for (int c = 0; c < 400; c++) begin
      case (mode)
        0: byte_ready = 1'b1;
        1: byte_ready = ($urandom_range(0, 2) != 0);
        default: byte_ready = (ph % 4 == 0) || (ph % 4 == 3);
      endcase
      ph++;
      if (noise) begin
        msg_valid = 1'b1;
        msg_in = rand_msg();
      end
      cyc();
      if (!busy) break;
      n_busy++;
    end
    msg_valid = 1'b0;
    check_eq("frame_end", {31'd0, busy}, 32'd0);
    if (chk_len) check_eq("busy_cycles", n_busy, FRAME_LEN);
    byte_ready = 1'b0;
    cyc();
  endtask

  task automatic check_kat(input string tag, input logic [8:0] kat[$]);
    check_eq({tag, "_len"}, cap_q.size(), kat.size());
    for (int i = 0; i < kat.size() && i < cap_q.size(); i++)
      check_eq(tag, {23'd0, cap_q[i]}, {23'd0, kat[i]});
  endtask

  logic [8:0] kat1[$];
  logic [8:0] kat0[$];

  initial begin
    kat1.push_back({1'b1, SOP_K});
    kat0.push_back({1'b1, SOP_K});
    for (int i = 0; i < 9; i++) begin
      kat1.push_back(9'h000);
      kat0.push_back(9'h000);
    end
    kat1.push_back(9'h010);
    kat0.push_back(9'h000);
`ifdef TRA_ELINK_CRC_EN
    kat1.push_back(9'h070);
    kat0.push_back(9'h000);
`endif
    kat1.push_back({1'b1, EOP_K});
    kat0.push_back({1'b1, EOP_K});

    rst = 1'b0;
    repeat (3) cyc();
    mon_en = 1'b1;
    check_eq("rst_byte", {24'd0, byte_out}, {24'd0, IDLE_K});
    check_eq("rst_k", {31'd0, kchar_out}, 32'd1);
    rst = 1'b1;
    cyc();

    run_frame(76'h1, 0, 0, 1);
    check_kat("kat_one", kat1);
    run_frame(76'h0, 0, 0, 1);
    check_kat("kat_zero", kat0);
    run_frame(76'h1, 2, 0, 0);
    check_kat("kat_stall", kat1);
    run_frame(76'h1, 1, 1, 0);
    check_kat("kat_noise", kat1);

    // reset while payload byte 4 is on the line, then a clean frame
    cap_q.delete();
    msg_in = rand_msg();
    msg_valid = 1'b1;
    byte_ready = 1'b1;
    cyc();
    msg_valid = 1'b0;
    repeat (5) cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check_eq("midrst_byte", {24'd0, byte_out}, {24'd0, IDLE_K});
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    run_frame(76'h1, 0, 0, 1);
    check_kat("kat_after_rst", kat1);

    for (int f = 0; f < 20; f++) run_frame(rand_msg(), f % 3, f[0], f % 3 == 0);

    // free-running random traffic, occasional reset
    for (int c = 0; c < 3000; c++) begin
      msg_valid = ($urandom_range(0, 3) == 0);
      msg_in = rand_msg();
      byte_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) != 0);
      cyc();
    end
    rst = 1'b1;
    msg_valid = 1'b0;
    byte_ready = 1'b0;
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tra_elink_framer.md
# tra_elink_framer

Transmit-side framer that sits directly downstream of the CAN transmit byte buffer. It accepts one 76-bit CAN message (11-bit COB-ID, control bits and data, packed MSB first) through a valid/ready handshake. It emits the message as a framed stream of 8-bit symbols with K-character flags: start-of-packet, 10 payload bytes, optional CRC-8, end-of-packet. That stream feeds the 8b10b encoder / e-link serializer, which paces the framer with a per-symbol `byte_ready` strobe.

## Interface
- `SOP_K`, 8'h3C, start-of-packet K-code (K.28.1)
- `EOP_K`, 8'hDC, end-of-packet K-code (K.28.6)
- `IDLE_K`, 8'hBC, idle/comma K-code (K.28.5)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-low
- `msg_in`  in  76  message to send; bit 75 transmitted first
- `msg_valid`  in  1  `msg_in` is valid
- `msg_ready`  out  1  framer can accept a message (high only in IDLE)
- `byte_ready`  in  1  downstream consumes the current symbol at this edge
- `byte_out`  out  8  current symbol
- `kchar_out`  out  1  `byte_out` is a K-code
- `busy`  out  1  frame in progress (state ≠ IDLE)
- `done`  out  1  one-cycle pulse when EOP is consumed

## Operation
- States: IDLE, SOP, PAYLOAD, CRC (only with macro), EOP. All outputs are registered.
- Reset values: state=IDLE, `byte_out`=`IDLE_K`, `kchar_out`=1, `msg_ready`=1, `busy`=0, `done`=0, byte counter=0, CRC=8'h00, shift register=0.
- IDLE:
  - Presents `IDLE_K`/K=1.
  - On `msg_valid && msg_ready`: load shift register with {`msg_in`, 4'h0} (80 bits); set `byte_out`<=`SOP_K`, K=1, `msg_ready`<=0, `busy`<=1, CRC<=0; go to SOP.
  - `byte_ready` is ignored in IDLE.
- SOP, on `byte_ready`:
  - `byte_out`<=shreg[79:72], K=0; shift left 8; counter<=0; fold the byte into CRC; go to PAYLOAD.
- PAYLOAD, on `byte_ready`:
  - Counter < 9: present the next byte, counter+1, fold it into CRC.
  - Counter = 9: present CRC (K=0, go to CRC) with macro, else present `EOP_K` (K=1, go to EOP).
- CRC, on `byte_ready`: `byte_out`<=`EOP_K`, K=1; go to EOP.
- EOP, on `byte_ready`:
  - `byte_out`<=`IDLE_K`, K=1; `done`<=1 for one cycle; `busy`<=0; `msg_ready`<=1; go to IDLE.
- Payload byte order:
  - byte0 = `msg_in`[75:68], …, byte8 = `msg_in`[11:4].
  - byte9 = {`msg_in`[3:0], 4'h0}; padding is always zero.
- CRC-8:
  - Polynomial x^8+x^2+x+1 (0x07), init 8'h00, MSB-first, no reflection, no final XOR.
  - Covers the 10 payload bytes including pad bits.
  - The CRC must be final when the PAYLOAD→CRC transition presents it.
- Boundary conditions:
  - `msg_valid` while busy: ignored, and `msg_in` is not sampled.
  - `byte_ready` low in any non-IDLE state: the current symbol and all state hold indefinitely.
  - `msg_in` changing after acceptance has no effect.
  - Reset low mid-frame: on the next edge all outputs return to reset values and the frame is discarded, with no EOP and no `done`.

## Timing
- Acceptance to SOP on `byte_out`: 1 cycle.
- Each symbol is held until a `byte_ready` edge; the next symbol appears the cycle after.
- Frame length: 12 symbols (13 with CRC).
- With `byte_ready` tied high:
  - Accept at edge N; SOP visible from N+1; byte0 from N+2; EOP at N+12 (N+13 with CRC).
  - `done` and `msg_ready` high the cycle after the EOP consume.
- Back-to-back frames: a new message is accepted on the first edge where `msg_ready`=1, so at least one IDLE symbol appears between frames.

## Configuration
- `TRA_ELINK_CRC_EN` defined:
  - CRC state and the CRC-8 register are compiled in; a CRC byte is inserted between byte9 and EOP.
- Undefined:
  - No CRC logic; PAYLOAD goes directly to EOP; frame is 12 symbols.

## Test plan
- Reset: hold `rst`=0 for 3 cycles → `byte_out`=8'hBC, K=1, `msg_ready`=1, `busy`=0, `done`=0.
- `msg_in`=76'h1, `byte_ready`=1, no macro:
  - Expect BC, 3C(K), then 00×9, 10, then DC(K), BC(K).
  - `done` high exactly 1 cycle; `busy` high for 12 cycles.
- Same message with `TRA_ELINK_CRC_EN`: expect 00×9, 10, 70, DC(K). A second frame with all-zero `msg_in` gives CRC 00.
- Stall: `byte_ready` toggling 1-0-0-1 during PAYLOAD → each byte held while low; no byte skipped or duplicated; same sequence as the previous test.
- `msg_valid`=1 with a different `msg_in` during the frame → ignored; the frame content is unchanged; the next message is accepted only after `done`.
- `rst`=0 at payload byte 4 → next cycle BC/K=1, `msg_ready`=1, no `done`; the next message is sent complete from SOP.
